// File: rtl/dm_bram_if.sv
// Request/return bundle for the dm_bram data memory: the CPU memory stage is the
// master, dm_bram is the slave.
interface dm_bram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              ena;
    logic [NB-1:0]     wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              valida;
    logic              erra;

    modport master (
        output ena, wea, addra, dina,
        input  douta, valida, erra
    );

    modport slave (
        input  ena, wea, addra, dina,
        output douta, valida, erra
    );
endinterface

// File: rtl/dm_bram.sv
// Single-port data memory with byte write enables, RD_LAT-cycle read return pipeline,
// optional read-first write returns and out-of-range flagging.
module dm_bram #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = 0
) (
    input logic      clka,
    input logic      resetn,
    dm_bram_if.slave mem_bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    logic              ena;
    logic [NB-1:0]     wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;

    assign ena   = mem_bus.ena;
    assign wea   = mem_bus.wea;
    assign addra = mem_bus.addra;
    assign dina  = mem_bus.dina;

    logic             in_rng;
    logic             is_wr;
    logic [IDX_W-1:0] idx;

    assign in_rng = addr_in_range(addra);
    assign is_wr  = |wea;
    assign idx    = addra[IDX_W-1:0];

    // Issue: the array read happens before this edge's write lands, which gives
    // read-first behaviour for free when WR_MODE selects it.
    logic              vld_in;
    logic              err_in;
    logic [DATA_W-1:0] dat_in;

    always_comb begin
        vld_in = ena && (!is_wr || (WR_MODE != 0));
        err_in = !in_rng;
        dat_in = in_rng ? mem[idx] : '0;
    end

    always_ff @(posedge clka) begin
        if (ena && in_rng) begin
            for (int b = 0; b < NB; b++) begin
                if (wea[b]) begin
                    mem[idx][8*b +: 8] <= dina[8*b +: 8];
                end
            end
        end
    end

    // Return pipeline: RD_LAT-1 intermediate stages, the output register is the last.
    logic              ret_vld;
    logic              ret_err;
    logic [DATA_W-1:0] ret_dat;

    generate
        if (RD_LAT > 1) begin : g_pipe
            localparam int NS = RD_LAT - 1;

            logic              vld_p [NS];
            logic              err_p [NS];
            logic [DATA_W-1:0] dat_p [NS];

            always_ff @(posedge clka or negedge resetn) begin
                if (!resetn) begin
                    for (int s = 0; s < NS; s++) begin
                        vld_p[s] <= 1'b0;
                    end
                end else begin
                    vld_p[0] <= vld_in;
                    for (int s = 1; s < NS; s++) begin
                        vld_p[s] <= vld_p[s-1];
                    end
                end
            end

            always_ff @(posedge clka) begin
                err_p[0] <= err_in;
                dat_p[0] <= dat_in;
                for (int s = 1; s < NS; s++) begin
                    err_p[s] <= err_p[s-1];
                    dat_p[s] <= dat_p[s-1];
                end
            end

            assign ret_vld = vld_p[NS-1];
            assign ret_err = err_p[NS-1];
            assign ret_dat = dat_p[NS-1];
        end else begin : g_direct
            assign ret_vld = vld_in;
            assign ret_err = err_in;
            assign ret_dat = dat_in;
        end
    endgenerate

    // Output stage: douta holds its last returned word until the next valid return.
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              rd_err;

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            rd_vld <= ret_vld;
            rd_err <= ret_vld && ret_err;
            if (ret_vld) begin
                rd_data <= ret_dat;
            end
        end
    end

    assign mem_bus.douta  = rd_data;
    assign mem_bus.valida = rd_vld;
    assign mem_bus.erra   = rd_err;
endmodule

// File: tb/tb_dm_bram.sv
// Directed bench for dm_bram: three configurations (RD_LAT 1/3/4, both write modes,
// power-of-two and odd depth) driven from per-cycle vector tables.
module tb_dm_bram;
    typedef struct packed {
        logic        ena;
        logic [3:0]  wea;
        logic [31:0] addr;
        logic [31:0] din;
        logic        v;
        logic        e;
        logic [31:0] d;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    dm_bram_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
    dm_bram_if #(.DATA_W(32), .ADDR_W(32)) if_b ();
    dm_bram_if #(.DATA_W(16), .ADDR_W(4))  if_c ();

    dm_bram #(.DATA_W(32), .DEPTH(4096), .ADDR_W(32), .RD_LAT(1), .WR_MODE(0)) u_a (
        .clka(clk), .resetn(rst_n), .mem_bus(if_a));
    dm_bram #(.DATA_W(32), .DEPTH(4096), .ADDR_W(32), .RD_LAT(3), .WR_MODE(1)) u_b (
        .clka(clk), .resetn(rst_n), .mem_bus(if_b));
    dm_bram #(.DATA_W(16), .DEPTH(10), .ADDR_W(4), .RD_LAT(4), .WR_MODE(0)) u_c (
        .clka(clk), .resetn(rst_n), .mem_bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task drive_a(input vec_t x);
        if_a.ena = x.ena; if_a.wea = x.wea; if_a.addra = x.addr; if_a.dina = x.din;
    endtask

    task drive_b(input vec_t x);
        if_b.ena = x.ena; if_b.wea = x.wea; if_b.addra = x.addr; if_b.dina = x.din;
    endtask

    task drive_c(input vec_t x);
        if_c.ena = x.ena; if_c.wea = x.wea[1:0]; if_c.addra = x.addr[3:0]; if_c.dina = x.din[15:0];
    endtask

    task check_a(input string tag, input vec_t x);
        check({tag, " valida"}, 32'(if_a.valida), 32'(x.v));
        check({tag, " erra"},   32'(if_a.erra),   32'(x.e));
        check({tag, " douta"},  if_a.douta,       x.d);
    endtask

    task check_b(input string tag, input vec_t x);
        check({tag, " valida"}, 32'(if_b.valida), 32'(x.v));
        check({tag, " erra"},   32'(if_b.erra),   32'(x.e));
        check({tag, " douta"},  if_b.douta,       x.d);
    endtask

    task check_c(input string tag, input vec_t x);
        check({tag, " valida"}, 32'(if_c.valida), 32'(x.v));
        check({tag, " erra"},   32'(if_c.erra),   32'(x.e));
        check({tag, " douta"},  {16'h0, if_c.douta}, x.d);
    endtask

    vec_t va [19];
    vec_t vb [14];
    vec_t vc [16];
    vec_t idle;
    vec_t zero_out;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle     = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        zero_out = idle;

        // RD_LAT=1, NO_CHANGE: expected outputs are those seen right after the vector's edge.
        va[0]  = '{1'b1, 4'hF, 32'd5,          32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000};
        va[1]  = '{1'b1, 4'h0, 32'd5,          32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        va[2]  = '{1'b1, 4'h2, 32'd5,          32'h00001200, 1'b0, 1'b0, 32'hDEADBEEF};
        va[3]  = '{1'b1, 4'h0, 32'd5,          32'h0,        1'b1, 1'b0, 32'hDEAD12EF};
        va[4]  = '{1'b1, 4'hF, 32'd0,          32'h01234567, 1'b0, 1'b0, 32'hDEAD12EF};
        va[5]  = '{1'b1, 4'hF, 32'd4096,       32'hFFFFFFFF, 1'b0, 1'b0, 32'hDEAD12EF};
        va[6]  = '{1'b1, 4'h0, 32'd4096,       32'h0,        1'b1, 1'b1, 32'h00000000};
        va[7]  = '{1'b1, 4'h0, 32'd0,          32'h0,        1'b1, 1'b0, 32'h01234567};
        va[8]  = '{1'b0, 4'hF, 32'd0,          32'hFFFFFFFF, 1'b0, 1'b0, 32'h01234567};
        va[9]  = '{1'b1, 4'h0, 32'd0,          32'h0,        1'b1, 1'b0, 32'h01234567};
        va[10] = '{1'b1, 4'hF, 32'd4095,       32'h11223344, 1'b0, 1'b0, 32'h01234567};
        va[11] = '{1'b1, 4'h8, 32'd4095,       32'hAB000000, 1'b0, 1'b0, 32'h01234567};
        va[12] = '{1'b1, 4'h0, 32'd4095,       32'h0,        1'b1, 1'b0, 32'hAB223344};
        va[13] = '{1'b1, 4'h0, 32'hFFFFFFFF,   32'h0,        1'b1, 1'b1, 32'h00000000};
        va[14] = '{1'b1, 4'h4, 32'd5,          32'h00770000, 1'b0, 1'b0, 32'h00000000};
        va[15] = '{1'b1, 4'h0, 32'd5,          32'h0,        1'b1, 1'b0, 32'hDE7712EF};
        va[16] = '{1'b1, 4'h0, 32'd4095,       32'h0,        1'b1, 1'b0, 32'hAB223344};
        va[17] = '{1'b0, 4'h0, 32'd5,          32'h0,        1'b0, 1'b0, 32'hAB223344};
        va[18] = '{1'b1, 4'h0, 32'd5,          32'h0,        1'b1, 1'b0, 32'hDE7712EF};

        // RD_LAT=3, READ_FIRST: outputs after edge k belong to the access issued at k-2.
        vb[0]  = '{1'b1, 4'h0, 32'd0,    32'h0,        1'b0, 1'b0, 32'hAAAA5555};
        vb[1]  = '{1'b1, 4'h0, 32'd1,    32'h0,        1'b0, 1'b0, 32'hAAAA5555};
        vb[2]  = '{1'b1, 4'h0, 32'd2,    32'h0,        1'b1, 1'b0, 32'h00000010};
        vb[3]  = '{1'b1, 4'h0, 32'd3,    32'h0,        1'b1, 1'b0, 32'h00000011};
        vb[4]  = '{1'b0, 4'h0, 32'd0,    32'h0,        1'b1, 1'b0, 32'h00000012};
        vb[5]  = '{1'b0, 4'h0, 32'd0,    32'h0,        1'b1, 1'b0, 32'h00000013};
        vb[6]  = '{1'b1, 4'hF, 32'd7,    32'h12345678, 1'b0, 1'b0, 32'h00000013};
        vb[7]  = '{1'b1, 4'h0, 32'd7,    32'h0,        1'b0, 1'b0, 32'h00000013};
        vb[8]  = '{1'b1, 4'hF, 32'd4096, 32'h55555555, 1'b1, 1'b0, 32'hAAAA5555};
        vb[9]  = '{1'b1, 4'h1, 32'd2,    32'h000000EE, 1'b1, 1'b0, 32'h12345678};
        vb[10] = '{1'b1, 4'h0, 32'd2,    32'h0,        1'b1, 1'b1, 32'h00000000};
        vb[11] = '{1'b0, 4'h0, 32'd0,    32'h0,        1'b1, 1'b0, 32'h00000012};
        vb[12] = '{1'b0, 4'h0, 32'd0,    32'h0,        1'b1, 1'b0, 32'h000000EE};
        vb[13] = '{1'b0, 4'h0, 32'd0,    32'h0,        1'b0, 1'b0, 32'h000000EE};

        // RD_LAT=4, NO_CHANGE, DEPTH=10, 16-bit: outputs after edge k belong to issue k-3.
        vc[0]  = '{1'b1, 4'h3, 32'd9,  32'h0000BEEF, 1'b0, 1'b0, 32'h0000};
        vc[1]  = '{1'b1, 4'h3, 32'd0,  32'h00001234, 1'b0, 1'b0, 32'h0000};
        vc[2]  = '{1'b1, 4'h3, 32'd10, 32'h0000FFFF, 1'b0, 1'b0, 32'h0000};
        vc[3]  = '{1'b0, 4'h3, 32'd0,  32'h0000AAAA, 1'b0, 1'b0, 32'h0000};
        vc[4]  = '{1'b1, 4'h3, 32'd3,  32'h00005A5A, 1'b0, 1'b0, 32'h0000};
        vc[5]  = '{1'b1, 4'h0, 32'd10, 32'h0,        1'b0, 1'b0, 32'h0000};
        vc[6]  = '{1'b1, 4'h0, 32'd0,  32'h0,        1'b0, 1'b0, 32'h0000};
        vc[7]  = '{1'b1, 4'h0, 32'd9,  32'h0,        1'b0, 1'b0, 32'h0000};
        vc[8]  = '{1'b1, 4'h0, 32'd15, 32'h0,        1'b1, 1'b1, 32'h0000};
        vc[9]  = '{1'b1, 4'h0, 32'd3,  32'h0,        1'b1, 1'b0, 32'h1234};
        vc[10] = '{1'b0, 4'h0, 32'd0,  32'h0,        1'b1, 1'b0, 32'hBEEF};
        vc[11] = '{1'b0, 4'h0, 32'd0,  32'h0,        1'b1, 1'b1, 32'h0000};
        vc[12] = '{1'b0, 4'h0, 32'd0,  32'h0,        1'b1, 1'b0, 32'h5A5A};
        vc[13] = '{1'b0, 4'h0, 32'd0,  32'h0,        1'b0, 1'b0, 32'h5A5A};
        vc[14] = '{1'b1, 4'h0, 32'd9,  32'h0,        1'b0, 1'b0, 32'h5A5A};
        vc[15] = '{1'b1, 4'h0, 32'd0,  32'h0,        1'b0, 1'b0, 32'h5A5A};

        rst_n = 1'b1;
        drive_a(idle);
        drive_b(idle);
        drive_c(idle);

        // Reset asserted mid-cycle: outputs must clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_a("por A", zero_out);
        check_b("por B", zero_out);
        check_c("por C", zero_out);
        step();
        step();
        #3 rst_n = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            drive_a(va[i]);
            step();
            check_a($sformatf("A[%0d]", i), va[i]);
        end
        drive_a(idle);

        // Async reset while douta holds a nonzero word and valida is high.
        #2 rst_n = 1'b0;
        #1;
        check_a("A async rst", zero_out);
        step();
        #3 rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            drive_b('{1'b1, 4'hF, 32'(i), 32'(16 + i), 1'b0, 1'b0, 32'h0});
            step();
        end
        drive_b('{1'b1, 4'hF, 32'd7, 32'hAAAA5555, 1'b0, 1'b0, 32'h0});
        step();
        drive_b(idle);
        repeat (3) step();
        drive_b('{1'b1, 4'h0, 32'd7, 32'h0, 1'b0, 1'b0, 32'h0});
        step();
        drive_b(idle);
        step();
        step();
        check_b("B prime", '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hAAAA5555});

        for (int i = 0; i < 14; i++) begin
            drive_b(vb[i]);
            step();
            check_b($sformatf("B[%0d]", i), vb[i]);
        end
        drive_b(idle);

        for (int i = 0; i < 16; i++) begin
            drive_c(vc[i]);
            step();
            check_c($sformatf("C[%0d]", i), vc[i]);
        end
        drive_c(idle);

        // Two reads in flight; reset must drop them and clear douta.
        #2 rst_n = 1'b0;
        #1;
        check_c("C async rst", zero_out);
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_c($sformatf("C flush[%0d]", i), zero_out);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_bram.md
# dm_bram

Parametrised, single-port synchronous data-memory model with per-byte write enables, configurable read latency, selectable write-cycle read mode and out-of-range detection. It replaces fixed 32-bit × 4096 BRAM models in the CPU's memory stage. It also gives the pipeline an explicit read-data valid strobe, so load latency can be varied without changing core logic.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- DEPTH, 4096, number of words; any value ≥ 2
- ADDR_W, 32, address port width; must satisfy 2^ADDR_W ≥ DEPTH
- RD_LAT, 1, read latency in cycles, 1..4
- WR_MODE, 0, 0 = NO_CHANGE (write cycle returns nothing), 1 = READ_FIRST (write cycle returns the pre-write word)
- NB = DATA_W/8, derived; not overridable

- clka  in  1  clock; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- ena  in  1  request strobe; one access per cycle while high
- wea  in  NB  byte write enables; bit i covers dina[8i+7:8i]; all zero = read
- addra  in  ADDR_W  word index (not byte address)
- dina  in  DATA_W  write data
- douta  out  DATA_W  read data; holds last returned word between returns
- valida  out  1  one-cycle pulse: douta carries a returned word this cycle
- erra  out  1  one-cycle pulse coincident with valida: returned access was out of range

## Operation
- Access classes, sampled at the rising edge of clka with ena=1:
  - READ: wea == 0.
  - WRITE: wea != 0.
- ena=0: no access. wea, addra and dina are ignored.
- In range means addra < DEPTH, compared on the full ADDR_W value. Addresses are never masked or aliased.
- WRITE, in range: only the enabled bytes are updated. Unenabled bytes keep their value.
- WRITE, out of range: memory is unchanged.
- READ: enters the return pipeline with captured word and range flag. Out-of-range reads return all zeros with erra=1.
- WRITE with WR_MODE=1: enters the return pipeline like a read.
  - Returns the word as it was before this edge's update.
  - Out-of-range writes in this mode return zeros with erra=1.
- WRITE with WR_MODE=0: nothing enters the pipeline; valida stays 0 for that slot.
- Return pipeline:
  - RD_LAT-deep shift of {valid, err, data}.
  - Advances every cycle and never stalls.
  - Back-to-back accesses return back-to-back in issue order.
- Memory array is not cleared by reset. Simulation initial contents are all zeros.
- On reset assertion, any time:
  - douta=0, valida=0, erra=0.
  - All pipeline stages are invalidated. In-flight reads are dropped, not returned after reset.
- A write at the same edge that resetn deasserts is not guaranteed. The bench drives ena=0 in the first cycle after release.

## Timing
- An access issued at edge N returns at edge N+RD_LAT.
  - valida, erra and douta update together.
  - With RD_LAT=1, data is visible the cycle after issue.
- Write commit: at edge N. A READ to the same address issued at edge N+1 returns the new data.
- Same-address write followed immediately by a read (distinct consecutive cycles) always sees the written bytes.
- douta changes only on edges where the returning stage is valid, or on reset.
- Reset is asynchronous: outputs go to 0 without waiting for a clka edge.
- Throughput: one access per cycle, sustained indefinitely.

## Test plan
- Reset, then a byte-merged write and read:
  - Stimulus: resetn low mid-cycle; then, with DATA_W=32, RD_LAT=1, write 0xDEADBEEF to addr 5 with wea=4'hF, then wea=4'b0010 with dina=0x00001200, then read addr 5.
  - Response: outputs 0 immediately on reset; read returns douta=0xDEADBEEF→0xDEAD12EF, valida=1 for one cycle, erra=0.
- RD_LAT=3 streaming:
  - Stimulus: reads of addrs 0,1,2,3 on consecutive cycles (preloaded 0x10..0x13).
  - Response: valida high 4 consecutive cycles starting 3 edges after first issue; data in order 0x10,0x11,0x12,0x13.
- Out-of-range access, DEPTH=4096:
  - Stimulus: write 0xFFFFFFFF to addr 4096, then read addr 4096, then read addr 0.
  - Response: addr-4096 read returns douta=0, erra=1. Addr 0 is unchanged (no aliasing).
- WR_MODE=1:
  - Stimulus: addr 7 holds 0xAAAA5555; write 0x12345678 to addr 7 with wea=4'hF; then read addr 7.
  - Response: the write cycle returns 0xAAAA5555 with valida=1; the read returns 0x12345678.
- WR_MODE=0 and ena gating:
  - Stimulus: write issued with ena=1, then a cycle with ena=0 and wea=4'hF.
  - Response: no valida pulse for either cycle; the ena=0 cycle does not modify memory.
- Reset mid-flight:
  - Stimulus: with RD_LAT=4, issue 2 reads, then pulse resetn low before either returns.
  - Response: valida never asserts for those reads; douta=0 after reset.
